native_port_buffer: RTL and testbench
=====================================

# native_port_buffer

Decoupling buffer between a user master and one native port of the 2-port LPDDR4 crossbar, sitting directly upstream of it; one instance per port. It queues commands and write data. A write command is issued only once its data beat is already buffered, so the crossbar never stalls on `wdata_ready`. Read issue is credit-limited so returning read data can always be absorbed without back-pressure.

## Interface
- `ADDR_W`, 24, native command address width
- `DATA_W`, 256, data beat width; `BE_W = DATA_W/8`
- `CMD_DEPTH`, 4, command FIFO entries (power of 2, ≥2)
- `WD_DEPTH`, 4, write-data FIFO entries (power of 2, ≥2)
- `RD_DEPTH`, 8, read-data FIFO entries and read credit (power of 2, ≥2)

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-low
- `usr_cmd_valid/usr_cmd_ready` in/out 1: user command handshake
- `usr_cmd_we` in 1: 1 = write
- `usr_cmd_addr` in ADDR_W: address
- `usr_wdata_valid/usr_wdata_ready` in/out 1: user write-data handshake
- `usr_wdata_data` in DATA_W; `usr_wdata_be` in BE_W: byte enables
- `usr_rdata_valid/usr_rdata_ready` out/in 1; `usr_rdata_data` out DATA_W
- `native_cmd_valid/native_cmd_ready` out/in 1
- `native_cmd_first`, `native_cmd_last` out 1: constant 1
- `native_cmd_payload_mw` out 1: constant 0
- `native_cmd_payload_we` out 1; `native_cmd_payload_addr` out ADDR_W
- `native_wdata_valid/native_wdata_ready` out/in 1
- `native_wdata_first`, `native_wdata_last` out 1: constant 1
- `native_wdata_payload_data` out DATA_W; `native_wdata_payload_we` out BE_W
- `native_rdata_valid` in 1; `native_rdata_ready` out 1: constant 1
- `native_rdata_first`, `native_rdata_last` in 1: ignored
- `native_rdata_payload_data` in DATA_W
- `rd_outstanding` out $clog2(RD_DEPTH)+1: issued reads not yet popped by the user
- `err_rd_overflow` out 1: sticky; set by native rdata arriving when the rdata FIFO is full

## Operation
- Three FIFOs:
  - cmd FIFO: {we, addr}
  - wd FIFO: {data, be}
  - rd FIFO: data
- Write debt counter `wr_owed`: +1 on write-command accept (`native_cmd_valid && native_cmd_ready && we`); −1 on native wdata handshake.
- Read credit `rd_credit`: resets to RD_DEPTH; −1 on read-command accept; +1 on user rdata pop. A simultaneous −1 and +1 leaves the counter unchanged. `rd_outstanding = RD_DEPTH − rd_credit`.
- `native_cmd_valid` = cmd FIFO not empty AND (head is a write ? `wd_count > wr_owed` : `rd_credit != 0`).
- Commands issue strictly in order; a blocked head blocks all younger commands.
- `native_wdata_valid` = `wr_owed != 0` (wd FIFO non-empty is then guaranteed). Payload is the wd FIFO head.
- Native rdata is pushed unconditionally. A push into a full rd FIFO is dropped and sets `err_rd_overflow`. Neither a drop nor an overflow is possible while the crossbar obeys protocol.
- User write data may arrive before, with, or after its command.

## Timing
- `usr_cmd_ready = !cmd_full` and `usr_wdata_ready = !wd_full`, driven from registered counts. No combinational path from native ready to user ready.
- Latencies:
  - user command accepted in cycle N → `native_cmd_valid` no earlier than N+1
  - user wdata push in N → counts toward `wd_count` in N+1
  - native rdata in N → `usr_rdata_valid` in N+1
- Full FIFO accepts a push in the same cycle as a pop: no (ready is based on the registered full flag).
- Reset (`rst`=0 at a clock edge), including mid-transfer:
  - all FIFOs empty, `wr_owed`=0, `rd_credit`=RD_DEPTH, `err_rd_overflow`=0
  - all valid outputs 0
  - `usr_cmd_ready`=1, `usr_wdata_ready`=1
  - in-flight data is discarded

## Configuration
- `NATIVE_PORT_BUFFER_PERF_EN` defined: adds outputs `perf_rd_cmds`, `perf_wr_cmds`, `perf_stall_cycles`, each 32 bits, reset 0, wrapping.
  - `perf_stall_cycles` counts cycles where the cmd FIFO is non-empty and `native_cmd_valid`=0.
- Macro undefined: the ports and counters are absent.

## Structure
- Shared package `native_port_buffer_pkg`:
  - `cmd_entry_t` struct {we, addr}
  - `wd_entry_t` struct {data, be}
  - default width localparams
- One sub-module `nb_sync_fifo` (WIDTH, DEPTH; push/pop/full/empty/count), instantiated three times.
- Counters and issue logic live in the top.

## Test plan
- Write command at addr 0x10, data 0xA5.. pushed 3 cycles later → `native_cmd_valid` rises only after the data is counted; one cmd handshake with we=1, then one wdata beat with be=all-ones.
- 9 reads with `usr_rdata_ready`=0 and an immediate native responder → exactly 8 commands issue, `rd_outstanding`=8; the 9th issues one cycle after the first user pop.
- Interleaved W,R,W with data pre-loaded → native order W,R,W, `wr_owed` peaks at 2, returns to 0.
- Read credit exhausted, plus a cycle with a simultaneous read issue and user pop → `rd_credit` unchanged that cycle.
- Inject native rdata with the rd FIFO full → `err_rd_overflow`=1 and stays set; reset with `rst`=0 for 1 cycle → 0, FIFOs empty, `rd_outstanding`=0.
- With `NATIVE_PORT_BUFFER_PERF_EN`: 5 reads and 3 writes with a 4-cycle write-data gap → `perf_rd_cmds`=5, `perf_wr_cmds`=3, `perf_stall_cycles`≥4.

Source files
------------

// File: rtl/native_port_buffer_pkg.sv
// ---------------------------------------------------------------------------
// native_port_buffer_pkg
// Shared types and default widths for the native-port decoupling buffer.
//   cmd_entry_t : one queued command {we, addr}
//   wd_entry_t  : one queued write-data beat {data, be}
// The struct types are sized at the default widths. The top keeps its FIFO
// entries as flat vectors so that it can still be re-parameterised.
// ---------------------------------------------------------------------------
package native_port_buffer_pkg;

  localparam int ADDR_W_DEF    = 24;
  localparam int DATA_W_DEF    = 256;
  localparam int BE_W_DEF      = DATA_W_DEF / 8;
  localparam int CMD_DEPTH_DEF = 4;
  localparam int WD_DEPTH_DEF  = 4;
  localparam int RD_DEPTH_DEF  = 8;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
  } cmd_entry_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [BE_W_DEF-1:0]   be;
  } wd_entry_t;

endpackage

// File: rtl/nb_sync_fifo.sv
// ---------------------------------------------------------------------------
// nb_sync_fifo
// Single-clock FIFO with registered occupancy count.
// The full and empty flags come from the registered count. A push while full
// is dropped, even when a pop happens in the same cycle. A pop while empty is
// ignored. The head entry is always visible on pop_data.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   push, push_data     : write request and entry
//   pop                 : consume the head entry
//   pop_data            : head entry (valid when !empty)
//   full, empty, count  : occupancy status (registered)
// ---------------------------------------------------------------------------
module nb_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/native_port_buffer.sv
// ---------------------------------------------------------------------------
// native_port_buffer
// Decoupling buffer between a user master and one native crossbar port.
// - Commands and write data are queued independently.
// - A write command issues only after its data beat is already buffered, so
//   the crossbar never waits on native_wdata_ready.
// - Read issue is limited by credits, so returning read data always has room
//   in the read FIFO.
// Optional feature: define NATIVE_PORT_BUFFER_PERF_EN to add the 32-bit
// wrapping counters perf_rd_cmds, perf_wr_cmds and perf_stall_cycles.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   usr_cmd_*                : user command stream {we, addr}
//   usr_wdata_*              : user write-data stream {data, be}
//   usr_rdata_*              : read data returned to the user
//   native_cmd_*             : command stream to the crossbar
//   native_wdata_*           : write data to the crossbar
//   native_rdata_*           : read data from the crossbar (always accepted)
//   rd_outstanding           : reads issued but not yet popped by the user
//   err_rd_overflow          : sticky flag, read data arrived with FIFO full
// ---------------------------------------------------------------------------
module native_port_buffer
  import native_port_buffer_pkg::*;
#(
  parameter  int ADDR_W    = ADDR_W_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int CMD_DEPTH = CMD_DEPTH_DEF,
  parameter  int WD_DEPTH  = WD_DEPTH_DEF,
  parameter  int RD_DEPTH  = RD_DEPTH_DEF,
  localparam int BE_W      = DATA_W / 8,
  localparam int RD_CW     = $clog2(RD_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usr_cmd_valid,
  output logic              usr_cmd_ready,
  input  logic              usr_cmd_we,
  input  logic [ADDR_W-1:0] usr_cmd_addr,
  input  logic              usr_wdata_valid,
  output logic              usr_wdata_ready,
  input  logic [DATA_W-1:0] usr_wdata_data,
  input  logic [BE_W-1:0]   usr_wdata_be,
  output logic              usr_rdata_valid,
  input  logic              usr_rdata_ready,
  output logic [DATA_W-1:0] usr_rdata_data,
  output logic              native_cmd_valid,
  input  logic              native_cmd_ready,
  output logic              native_cmd_first,
  output logic              native_cmd_last,
  output logic              native_cmd_payload_mw,
  output logic              native_cmd_payload_we,
  output logic [ADDR_W-1:0] native_cmd_payload_addr,
  output logic              native_wdata_valid,
  input  logic              native_wdata_ready,
  output logic              native_wdata_first,
  output logic              native_wdata_last,
  output logic [DATA_W-1:0] native_wdata_payload_data,
  output logic [BE_W-1:0]   native_wdata_payload_we,
  input  logic              native_rdata_valid,
  output logic              native_rdata_ready,
  input  logic              native_rdata_first,
  input  logic              native_rdata_last,
  input  logic [DATA_W-1:0] native_rdata_payload_data,
  output logic [RD_CW-1:0]  rd_outstanding,
`ifdef NATIVE_PORT_BUFFER_PERF_EN
  output logic [31:0]       perf_rd_cmds,
  output logic [31:0]       perf_wr_cmds,
  output logic [31:0]       perf_stall_cycles,
`endif
  output logic              err_rd_overflow
);

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int WD_CW  = $clog2(WD_DEPTH) + 1;
  localparam int CMD_W  = ADDR_W + 1;
  localparam int WD_W   = DATA_W + BE_W;

  // FIFO status and heads
  logic              cmd_full, cmd_empty;
  logic [CMD_CW-1:0] cmd_count;
  logic [CMD_W-1:0]  cmd_head;
  logic              wd_full, wd_empty;
  logic [WD_CW-1:0]  wd_count;
  logic [WD_W-1:0]   wd_head;
  logic              rd_full, rd_empty;
  logic [RD_CW-1:0]  rd_count;

  // Issue bookkeeping
  logic [WD_CW-1:0]  wr_owed;    // write commands issued whose beat is not yet sent
  logic [RD_CW-1:0]  rd_credit;  // free read-FIFO slots not yet promised to a read
  logic              head_we;
  logic              cmd_fire, wr_fire, rd_fire, wd_fire, pop_fire;

  // Constant framing: every transfer is a single beat, never masked-write.
  assign native_cmd_first      = 1'b1;
  assign native_cmd_last       = 1'b1;
  assign native_cmd_payload_mw = 1'b0;
  assign native_wdata_first    = 1'b1;
  assign native_wdata_last     = 1'b1;
  assign native_rdata_ready    = 1'b1;

  // User-side ready depends only on registered occupancy.
  assign usr_cmd_ready   = !cmd_full;
  assign usr_wdata_ready = !wd_full;
  assign usr_rdata_valid = !rd_empty;

  nb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (usr_cmd_valid && usr_cmd_ready),
    .push_data ({usr_cmd_we, usr_cmd_addr}),
    .pop       (cmd_fire),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  nb_sync_fifo #(.WIDTH(WD_W), .DEPTH(WD_DEPTH)) u_wd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (usr_wdata_valid && usr_wdata_ready),
    .push_data ({usr_wdata_data, usr_wdata_be}),
    .pop       (wd_fire),
    .pop_data  (wd_head),
    .full      (wd_full),
    .empty     (wd_empty),
    .count     (wd_count)
  );

  // Read data is pushed unconditionally; the credit scheme keeps it from
  // ever arriving while full unless the crossbar misbehaves.
  nb_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (native_rdata_valid),
    .push_data (native_rdata_payload_data),
    .pop       (pop_fire),
    .pop_data  (usr_rdata_data),
    .full      (rd_full),
    .empty     (rd_empty),
    .count     (rd_count)
  );

  assign head_we                   = cmd_head[ADDR_W];
  assign native_cmd_payload_we     = head_we;
  assign native_cmd_payload_addr   = cmd_head[ADDR_W-1:0];
  assign native_wdata_payload_data = wd_head[WD_W-1:BE_W];
  assign native_wdata_payload_we   = wd_head[BE_W-1:0];

  // A write may issue only when a buffered beat exists that is not already
  // owed to an earlier write. A read needs a free credit. A blocked head
  // stalls everything behind it, which keeps issue strictly in order.
  // NOTE: always_comb assigns a default first so no path leaves the output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    native_cmd_valid = 1'b0;
    if (!cmd_empty) begin
      native_cmd_valid = head_we ? (wd_count > wr_owed) : (rd_credit != '0);
    end
  end

  // wd FIFO holds at least wr_owed beats, so this never presents a bubble.
  assign native_wdata_valid = (wr_owed != '0);

  assign cmd_fire = native_cmd_valid && native_cmd_ready;
  assign wr_fire  = cmd_fire && head_we;
  assign rd_fire  = cmd_fire && !head_we;
  assign wd_fire  = native_wdata_valid && native_wdata_ready;
  assign pop_fire = usr_rdata_valid && usr_rdata_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_owed <= '0;
    end else begin
      case ({wr_fire, wd_fire})
        2'b10:   wr_owed <= wr_owed + WD_CW'(1);
        2'b01:   wr_owed <= wr_owed - WD_CW'(1);
        default: wr_owed <= wr_owed;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_credit <= RD_CW'(RD_DEPTH);
    end else begin
      case ({rd_fire, pop_fire})
        2'b10:   rd_credit <= rd_credit - RD_CW'(1);
        2'b01:   rd_credit <= rd_credit + RD_CW'(1);
        default: rd_credit <= rd_credit;
      endcase
    end
  end

  assign rd_outstanding = RD_CW'(RD_DEPTH) - rd_credit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_rd_overflow <= 1'b0;
    end else if (native_rdata_valid && rd_full) begin
      err_rd_overflow <= 1'b1;
    end
  end

`ifdef NATIVE_PORT_BUFFER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_rd_cmds      <= '0;
      perf_wr_cmds      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (rd_fire) perf_rd_cmds <= perf_rd_cmds + 32'd1;
      if (wr_fire) perf_wr_cmds <= perf_wr_cmds + 32'd1;
      if (!cmd_empty && !native_cmd_valid) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  // Framing inputs carry no information for single-beat transfers.
  logic unused_ok;
  assign unused_ok = &{1'b0, native_rdata_first, native_rdata_last,
                       cmd_count, rd_count, wd_empty};

endmodule

// File: tb/tb_native_port_buffer.sv
// ---------------------------------------------------------------------------
// tb_native_port_buffer
// Scoreboard bench for native_port_buffer.
// - Expected native commands and write beats are queued as the user side
//   drives them, and compared when the DUT hands them to the crossbar.
// - A model crossbar answers every read one cycle after issue with data
//   derived from the address, and queues the matching user-side expectation.
// ---------------------------------------------------------------------------
module tb_native_port_buffer;
  import native_port_buffer_pkg::*;

  localparam int RD_CW = $clog2(RD_DEPTH_DEF) + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  usr_cmd_valid = 1'b0, usr_cmd_ready, usr_cmd_we = 1'b0;
  logic [ADDR_W_DEF-1:0] usr_cmd_addr = '0;
  logic                  usr_wdata_valid = 1'b0, usr_wdata_ready;
  logic [DATA_W_DEF-1:0] usr_wdata_data = '0;
  logic [BE_W_DEF-1:0]   usr_wdata_be = '0;
  logic                  usr_rdata_valid, usr_rdata_ready = 1'b0;
  logic [DATA_W_DEF-1:0] usr_rdata_data;
  logic                  native_cmd_valid, native_cmd_ready = 1'b0;
  logic                  native_cmd_first, native_cmd_last, native_cmd_payload_mw;
  logic                  native_cmd_payload_we;
  logic [ADDR_W_DEF-1:0] native_cmd_payload_addr;
  logic                  native_wdata_valid, native_wdata_ready = 1'b0;
  logic                  native_wdata_first, native_wdata_last;
  logic [DATA_W_DEF-1:0] native_wdata_payload_data;
  logic [BE_W_DEF-1:0]   native_wdata_payload_we;
  logic                  native_rdata_valid = 1'b0, native_rdata_ready;
  logic [DATA_W_DEF-1:0] native_rdata_payload_data = '0;
  logic [RD_CW-1:0]      rd_outstanding;
  logic                  err_rd_overflow;
`ifdef NATIVE_PORT_BUFFER_PERF_EN
  logic [31:0]           perf_rd_cmds, perf_wr_cmds, perf_stall_cycles;
`endif

  native_port_buffer dut (
    .clk                       (clk),
    .rst                       (rst),
    .usr_cmd_valid             (usr_cmd_valid),
    .usr_cmd_ready             (usr_cmd_ready),
    .usr_cmd_we                (usr_cmd_we),
    .usr_cmd_addr              (usr_cmd_addr),
    .usr_wdata_valid           (usr_wdata_valid),
    .usr_wdata_ready           (usr_wdata_ready),
    .usr_wdata_data            (usr_wdata_data),
    .usr_wdata_be              (usr_wdata_be),
    .usr_rdata_valid           (usr_rdata_valid),
    .usr_rdata_ready           (usr_rdata_ready),
    .usr_rdata_data            (usr_rdata_data),
    .native_cmd_valid          (native_cmd_valid),
    .native_cmd_ready          (native_cmd_ready),
    .native_cmd_first          (native_cmd_first),
    .native_cmd_last           (native_cmd_last),
    .native_cmd_payload_mw     (native_cmd_payload_mw),
    .native_cmd_payload_we     (native_cmd_payload_we),
    .native_cmd_payload_addr   (native_cmd_payload_addr),
    .native_wdata_valid        (native_wdata_valid),
    .native_wdata_ready        (native_wdata_ready),
    .native_wdata_first        (native_wdata_first),
    .native_wdata_last         (native_wdata_last),
    .native_wdata_payload_data (native_wdata_payload_data),
    .native_wdata_payload_we   (native_wdata_payload_we),
    .native_rdata_valid        (native_rdata_valid),
    .native_rdata_ready        (native_rdata_ready),
    .native_rdata_first        (1'b1),
    .native_rdata_last         (1'b1),
    .native_rdata_payload_data (native_rdata_payload_data),
    .rd_outstanding            (rd_outstanding),
`ifdef NATIVE_PORT_BUFFER_PERF_EN
    .perf_rd_cmds              (perf_rd_cmds),
    .perf_wr_cmds              (perf_wr_cmds),
    .perf_stall_cycles         (perf_stall_cycles),
`endif
    .err_rd_overflow           (err_rd_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_rd_iss = 0;
  int n_wd_beats = 0;

  cmd_entry_t            exp_cmd [$];
  wd_entry_t             exp_wd  [$];
  logic [DATA_W_DEF-1:0] exp_rd  [$];
  logic [DATA_W_DEF-1:0] resp_q  [$];
  logic                  inj_valid = 1'b0;
  logic [DATA_W_DEF-1:0] inj_data  = '0;

  task automatic check(input string tag, input logic [DATA_W_DEF-1:0] got,
                       input logic [DATA_W_DEF-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W_DEF-1:0] rd_pat(input logic [ADDR_W_DEF-1:0] a);
    return {8{8'h5A, a}};
  endfunction

  // Scoreboard: observe handshakes on the negedge before the edge that
  // completes them.
  always @(negedge clk) begin
    if (rst) begin
      if (native_cmd_valid && native_cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_unexpected", native_cmd_valid, 1'b0);
        end else begin
          cmd_entry_t e;
          e = exp_cmd.pop_front();
          check("cmd_we", native_cmd_payload_we, e.we);
          check("cmd_addr", native_cmd_payload_addr, e.addr);
          if (!e.we) begin
            n_rd_iss++;
            resp_q.push_back(rd_pat(e.addr));
            exp_rd.push_back(rd_pat(e.addr));
          end
        end
      end
      if (native_wdata_valid && native_wdata_ready) begin
        if (exp_wd.size() == 0) begin
          check("wd_unexpected", native_wdata_valid, 1'b0);
        end else begin
          wd_entry_t w;
          w = exp_wd.pop_front();
          n_wd_beats++;
          check("wd_data", native_wdata_payload_data, w.data);
          check("wd_be", native_wdata_payload_we, w.be);
        end
      end
      if (usr_rdata_valid && usr_rdata_ready) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", usr_rdata_valid, 1'b0);
        end else begin
          check("rd_data", usr_rdata_data, exp_rd.pop_front());
        end
      end
    end
  end

  // Model crossbar: returns each issued read one cycle after its handshake.
  always @(posedge clk) begin
    #1;
    if (inj_valid) begin
      native_rdata_valid        = 1'b1;
      native_rdata_payload_data = inj_data;
    end else if (resp_q.size() != 0) begin
      native_rdata_valid        = 1'b1;
      native_rdata_payload_data = resp_q.pop_front();
    end else begin
      native_rdata_valid        = 1'b0;
    end
  end

  task automatic send_cmd(input logic we, input logic [ADDR_W_DEF-1:0] addr);
    cmd_entry_t e;
    @(posedge clk); #1;
    usr_cmd_valid = 1'b1;
    usr_cmd_we    = we;
    usr_cmd_addr  = addr;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (usr_cmd_ready) break;
    end
    check("cmd_accept", usr_cmd_ready, 1'b1);
    e.we   = we;
    e.addr = addr;
    exp_cmd.push_back(e);
    @(posedge clk); #1;
    usr_cmd_valid = 1'b0;
  endtask

  task automatic send_wd(input logic [DATA_W_DEF-1:0] data, input logic [BE_W_DEF-1:0] be);
    wd_entry_t w;
    @(posedge clk); #1;
    usr_wdata_valid = 1'b1;
    usr_wdata_data  = data;
    usr_wdata_be    = be;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (usr_wdata_ready) break;
    end
    check("wd_accept", usr_wdata_ready, 1'b1);
    w.data = data;
    w.be   = be;
    exp_wd.push_back(w);
    @(posedge clk); #1;
    usr_wdata_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int busy;
    busy = 1;
    for (int i = 0; i < 500 && busy != 0; i++) begin
      @(negedge clk);
      busy = exp_cmd.size() + exp_wd.size() + exp_rd.size() + resp_q.size();
    end
    check(tag, busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", usr_cmd_ready, 1'b1);
    check("rst_wd_ready", usr_wdata_ready, 1'b1);
    check("rst_cmd_valid", native_cmd_valid, 1'b0);
    check("rst_wd_valid", native_wdata_valid, 1'b0);
    check("rst_rd_valid", usr_rdata_valid, 1'b0);
    check("rst_outstanding", rd_outstanding, 0);
    check("rst_err", err_rd_overflow, 1'b0);
    check("const_rdata_ready", native_rdata_ready, 1'b1);
    check("const_framing", {native_cmd_first, native_cmd_last, native_wdata_first,
                            native_wdata_last, native_cmd_payload_mw}, 5'b11110);

    // Write whose data arrives 3 cycles after the command
    native_cmd_ready   = 1'b1;
    native_wdata_ready = 1'b1;
    send_cmd(1'b1, 24'h10);
    repeat (3) begin
      @(negedge clk);
      check("wr_gated", native_cmd_valid, 1'b0);
    end
    send_wd({32{8'hA5}}, '1);
    @(negedge clk);
    check("wr_released", native_cmd_valid, 1'b1);
    wait_drain("drain_write");

    // Nine reads with the user not popping: credit stops at eight
    usr_rdata_ready = 1'b0;
    base = n_rd_iss;
    for (int i = 0; i < 9; i++) send_cmd(1'b0, 24'h100 + 24'(i));
    repeat (10) @(negedge clk);
    check("rd_issued_8", n_rd_iss - base, 8);
    check("rd_out_8", rd_outstanding, 8);
    check("rd_head_blocked", native_cmd_valid, 1'b0);
    @(posedge clk); #1 usr_rdata_ready = 1'b1;
    @(negedge clk);
    check("rd_blocked_pre_pop", native_cmd_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_9th_valid", native_cmd_valid, 1'b1);
    check("rd_out_after_pop", rd_outstanding, 7);
    @(posedge clk); #1 usr_rdata_ready = 1'b0;
    @(negedge clk);
    check("rd_simul_out", rd_outstanding, 7);
    check("rd_simul_credit", dut.rd_credit, 1);
    check("rd_issued_9", n_rd_iss - base, 9);
    @(posedge clk); #1 usr_rdata_ready = 1'b1;
    wait_drain("drain_reads");
    check("rd_out_zero", rd_outstanding, 0);

    // Data preloaded, then W,R,W: both writes issue before any beat is sent
    @(posedge clk); #1 native_wdata_ready = 1'b0;
    send_wd({16{16'hBEEF}}, '1);
    send_wd({8{32'h1234_5678}}, 32'h0F0F_00FF);
    base = n_wd_beats;
    send_cmd(1'b1, 24'h200);
    send_cmd(1'b0, 24'h210);
    send_cmd(1'b1, 24'h220);
    repeat (6) @(negedge clk);
    check("owed_peak", dut.wr_owed, 2);
    check("wd_valid_pending", native_wdata_valid, 1'b1);
    @(posedge clk); #1 native_wdata_ready = 1'b1;
    wait_drain("drain_wrw");
    check("owed_zero", dut.wr_owed, 0);
    check("wd_beats", n_wd_beats - base, 2);
    check("wd_valid_idle", native_wdata_valid, 1'b0);

    // Fill the read FIFO, then inject an unsolicited beat
    @(posedge clk); #1 usr_rdata_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_cmd(1'b0, 24'h300 + 24'(i));
    repeat (10) @(negedge clk);
    check("ovf_pre_out", rd_outstanding, 8);
    check("ovf_pre_err", err_rd_overflow, 1'b0);
    inj_data  = {8{32'hDEAD_BEEF}};
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    @(negedge clk);
    check("ovf_err_set", err_rd_overflow, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_err_sticky", err_rd_overflow, 1'b1);

    // One-cycle reset with data still buffered
    @(posedge clk); #1 rst = 1'b0;
    exp_cmd.delete();
    exp_wd.delete();
    exp_rd.delete();
    resp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_err", err_rd_overflow, 1'b0);
    check("rst2_rd_valid", usr_rdata_valid, 1'b0);
    check("rst2_out", rd_outstanding, 0);
    check("rst2_cmd_valid", native_cmd_valid, 1'b0);
    check("rst2_wd_valid", native_wdata_valid, 1'b0);
    check("rst2_readies", {usr_cmd_ready, usr_wdata_ready}, 2'b11);

`ifdef NATIVE_PORT_BUFFER_PERF_EN
    // Counters after 5 reads and 3 writes, the first write starved of data
    usr_rdata_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_cmd(1'b0, 24'h500 + 24'(i));
    send_cmd(1'b1, 24'h600);
    repeat (4) @(negedge clk);
    send_wd({8{32'hCAFE_0001}}, '1);
    send_cmd(1'b1, 24'h610);
    send_wd({8{32'hCAFE_0002}}, '1);
    send_cmd(1'b1, 24'h620);
    send_wd({8{32'hCAFE_0003}}, '1);
    wait_drain("drain_perf");
    check("perf_rd", perf_rd_cmds, 5);
    check("perf_wr", perf_wr_cmds, 3);
    check("perf_stall_ge4", perf_stall_cycles >= 32'd4, 1'b1);
`endif

    // Normal operation resumes after reset
    usr_rdata_ready = 1'b1;
    send_cmd(1'b0, 24'h7A0);
    send_wd({8{32'h0BAD_F00D}}, 32'hFFFF_0000);
    send_cmd(1'b1, 24'h7B0);
    wait_drain("drain_post_reset");
    check("post_out", rd_outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
